// File: rtl/fft_pkg.sv
// Shared constants and controller state type for the FFT frame controller.
package fft_pkg;
    localparam int FFT_N      = 16;
    localparam int BIN_W      = $clog2(FFT_N);
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        FILL,
        ARM,
        BURST,
        DRAIN
    } fft_state_e;
endpackage

// File: rtl/fft_frame_buf.sv
// Frame sample store: one write port, one read port with registered read (1 cycle).
// No backpressure; the controller never reads and writes the same frame concurrently.
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int W     = 2 * DATA_W_DEF,
    parameter int DEPTH = FFT_N,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end
endmodule

// File: rtl/fft_frame_ctrl.sv
// Gathers FFT_N samples, bursts them into the FFT core, tags results 1 cycle after arrival.
// o_ready is high only in FILL. Optional DRAIN timeout when FFT_CTRL_TIMEOUT_EN is defined.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_re,
    input  logic [DATA_W-1:0] i_im,
    output logic              o_ready,
    output logic              o_fft_valid,
    output logic [DATA_W-1:0] o_fft_re,
    output logic [DATA_W-1:0] o_fft_im,
    input  logic              i_fft_valid,
    input  logic              i_fft_busy,
    input  logic [DATA_W-1:0] i_fft_re,
    input  logic [DATA_W-1:0] i_fft_im,
    input  logic              i_err_clr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_re,
    output logic [DATA_W-1:0] o_im,
    output logic [BIN_W-1:0]  o_bin,
    output logic              o_sof,
    output logic              o_eof,
    output logic [7:0]        o_frame_cnt,
    output logic              o_busy,
    output logic              o_err
);
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FFT_N - 1);

    fft_state_e          state, next_state;
    logic [BIN_W-1:0]    wr_ptr, rd_ptr, out_cnt, rd_addr;
    logic                rd_en, accept, beat, last_beat, frame_done, timeout, fft_vld;
    logic [2*DATA_W-1:0] rd_dat;

    assign accept    = i_valid && o_ready;
    assign beat      = i_fft_valid && (state == BURST || state == DRAIN);
    assign last_beat = beat && (out_cnt == LAST_IDX);

    fft_frame_buf #(.W(2 * DATA_W), .DEPTH(FFT_N)) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_dat  ({i_re, i_im}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    // Read one entry ahead so the registered read lines up with each BURST cycle.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_addr    = rd_ptr + BIN_W'(1);
        case (state)
            FILL:  if (accept && wr_ptr == LAST_IDX) next_state = ARM;
            ARM: begin
                if (!i_fft_busy) begin
                    next_state = BURST;
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                end
            end
            BURST: begin
                if (rd_ptr == LAST_IDX) next_state = DRAIN;
                else                    rd_en = 1'b1;
            end
            DRAIN: if (last_beat || frame_done || timeout) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset)             timer <= '0;
        else if (state == DRAIN) timer <= timer + TIMER_W'(1);
        else                     timer <= '0;
    end

    assign timeout = (state == DRAIN) && (timer == TIMER_W'(TIMEOUT_CYC - 1))
                     && !last_beat && !frame_done;
`else
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_cnt     <= '0;
            frame_done  <= 1'b0;
            fft_vld     <= 1'b0;
            o_valid     <= 1'b0;
            o_re        <= '0;
            o_im        <= '0;
            o_bin       <= '0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_frame_cnt <= '0;
            o_err       <= 1'b0;
        end else begin
            state      <= next_state;
            fft_vld    <= (next_state == BURST);
            frame_done <= (state == BURST) && (frame_done || last_beat);
            if (accept)          wr_ptr <= wr_ptr + BIN_W'(1);
            if (state == BURST)  rd_ptr <= rd_ptr + BIN_W'(1);

            if (last_beat || timeout) out_cnt <= '0;
            else if (beat)            out_cnt <= out_cnt + BIN_W'(1);
            if (last_beat) o_frame_cnt <= o_frame_cnt + 8'd1;

            o_valid <= beat;
            o_re    <= beat ? i_fft_re : '0;
            o_im    <= beat ? i_fft_im : '0;
            o_bin   <= beat ? out_cnt : '0;
            o_sof   <= beat && (out_cnt == '0);
            o_eof   <= last_beat;

            // A stray result outside BURST/DRAIN wins over a same-cycle clear.
            if ((i_fft_valid && !beat) || timeout) o_err <= 1'b1;
            else if (i_err_clr)                    o_err <= 1'b0;
        end
    end

    assign o_ready     = (state == FILL);
    assign o_busy      = (state != FILL);
    assign o_fft_valid = fft_vld;
    assign o_fft_re    = fft_vld ? rd_dat[2*DATA_W-1:DATA_W] : '0;
    assign o_fft_im    = fft_vld ? rd_dat[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl with a frame-level reference model and directed literal checks.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          i_reset, i_valid, i_fft_valid, i_fft_busy, i_err_clr;
    logic [DW-1:0] i_re, i_im, i_fft_re, i_fft_im;
    logic          o_ready, o_fft_valid, o_valid, o_sof, o_eof, o_busy, o_err;
    logic [DW-1:0] o_fft_re, o_fft_im, o_re, o_im;
    logic [3:0]    o_bin;
    logic [7:0]    o_frame_cnt;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_re(i_re), .i_im(i_im),
        .o_ready(o_ready), .o_fft_valid(o_fft_valid), .o_fft_re(o_fft_re), .o_fft_im(o_fft_im),
        .i_fft_valid(i_fft_valid), .i_fft_busy(i_fft_busy), .i_fft_re(i_fft_re), .i_fft_im(i_fft_im),
        .i_err_clr(i_err_clr), .o_valid(o_valid), .o_re(o_re), .o_im(o_im), .o_bin(o_bin),
        .o_sof(o_sof), .o_eof(o_eof), .o_frame_cnt(o_frame_cnt), .o_busy(o_busy), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model (frame/phase level) ----------------
    localparam int PH_FILL = 0, PH_WAIT = 1, PH_SEND = 2, PH_COLLECT = 3;
    int            phase, sent, got, drain_len;
    bit            live = 1'b0, done_early, cnt, lst;
    logic [31:0]   fill_q [$];
    logic [31:0]   frame_mem [FFT_N];
    logic [7:0]    exp_fcnt;
    bit            exp_err, rv, rsof, reof;
    logic [DW-1:0] rre, rim;
    int            rbin;

    task automatic model_reset();
        phase = PH_FILL; sent = 0; got = 0; drain_len = 0; done_early = 0;
        fill_q.delete(); exp_fcnt = '0; exp_err = 0; rv = 0; rsof = 0; reof = 0;
    endtask

    always @(negedge clk) begin
        if (i_reset) begin
            live = 1'b1;
            chk("rst_ready", o_ready, 1);
            chk("rst_busy", o_busy, 0);
            chk("rst_fft_valid", o_fft_valid, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_frame_cnt", o_frame_cnt, 0);
            chk("rst_err", o_err, 0);
            model_reset();
        end else if (live) begin
            chk("ready", o_ready, phase == PH_FILL);
            chk("busy", o_busy, phase != PH_FILL);
            chk("fft_valid", o_fft_valid, phase == PH_SEND);
            chk("fft_re", o_fft_re, (phase == PH_SEND) ? frame_mem[sent][31:16] : 16'h0);
            chk("fft_im", o_fft_im, (phase == PH_SEND) ? frame_mem[sent][15:0] : 16'h0);
            chk("valid", o_valid, rv);
            if (rv) begin
                chk("res_re", o_re, rre);
                chk("res_im", o_im, rim);
                chk("bin", o_bin, rbin);
            end
            chk("sof", o_sof, rsof);
            chk("eof", o_eof, reof);
            chk("frame_cnt", o_frame_cnt, exp_fcnt);
            chk("err", o_err, exp_err);

            cnt  = i_fft_valid && (phase == PH_SEND || phase == PH_COLLECT);
            lst  = cnt && (got == FFT_N - 1);
            rv   = cnt; rre = i_fft_re; rim = i_fft_im; rbin = got;
            rsof = cnt && (got == 0);
            reof = lst;
            if (i_err_clr) exp_err = 0;
            if (i_fft_valid && !cnt) exp_err = 1;
            if (lst) begin got = 0; exp_fcnt = exp_fcnt + 8'd1; end
            else if (cnt) got++;
            case (phase)
                PH_FILL: if (i_valid) begin
                    fill_q.push_back({i_re, i_im});
                    if (fill_q.size() == FFT_N) begin
                        for (int i = 0; i < FFT_N; i++) frame_mem[i] = fill_q[i];
                        fill_q.delete();
                        phase = PH_WAIT;
                    end
                end
                PH_WAIT: if (!i_fft_busy) begin phase = PH_SEND; sent = 0; end
                PH_SEND: begin
                    if (lst) done_early = 1;
                    sent++;
                    if (sent == FFT_N) begin phase = PH_COLLECT; drain_len = 0; end
                end
                default: begin
                    drain_len++;
                    if (lst || done_early) begin phase = PH_FILL; done_early = 0; end
`ifdef FFT_CTRL_TIMEOUT_EN
                    else if (drain_len == TO) begin exp_err = 1; got = 0; phase = PH_FILL; end
`endif
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic feed(input int n, input bit rnd, input bit ramp);
        int acc = 0;
        int guard = 0;
        while (acc < n && guard < 2000) begin
            i_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_re    = ramp ? DW'(acc) : DW'($urandom);
            i_im    = ramp ? DW'(-acc) : DW'($urandom);
            @(negedge clk);
            if (i_valid && o_ready) acc++;
            cyc();
            guard++;
        end
        i_valid = 0;
        if (acc < n) bound_fail("feed");
    endtask

    task automatic fft_return(input int lat, input int beats, input int gap_pct);
        int g = 0;
        while (!o_fft_valid && g < 500) begin
            i_valid = 1'($urandom_range(0, 1));
            cyc(); g++;
        end
        if (g >= 500) bound_fail("burst_start");
        repeat (lat) cyc();
        for (int b = 0; b < beats;) begin
            i_valid     = 1'($urandom_range(0, 1));
            i_fft_valid = ($urandom_range(0, 99) >= gap_pct);
            i_fft_re    = DW'($urandom);
            i_fft_im    = DW'($urandom);
            if (i_fft_valid) b++;
            cyc();
        end
        i_fft_valid = 0;
        i_valid     = 0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!o_ready && g < 600) begin cyc(); g++; end
        if (g >= 600) bound_fail("wait_idle");
    endtask

    task automatic run_frame(input bit rnd);
        int busy_n = rnd ? $urandom_range(0, 12) : 0;
        i_fft_busy = (busy_n > 0);
        feed(FFT_N, rnd, 0);
        repeat (busy_n) cyc();
        i_fft_busy = 0;
        if (rnd) fft_return($urandom_range(0, 20), FFT_N, $urandom_range(0, 1) ? 0 : 40);
        else     fft_return(2, FFT_N, 0);
        wait_idle();
    endtask

    initial begin
        logic [DW-1:0] e;
        i_reset = 0; i_valid = 0; i_re = '0; i_im = '0; i_fft_valid = 0; i_fft_busy = 0;
        i_fft_re = '0; i_fft_im = '0; i_err_clr = 0;
        cyc();
        i_reset = 1;
        repeat (3) cyc();
        i_reset = 0;
        cyc();

        // Ramp frame with the FFT busy for 10 cycles after the buffer fills.
        i_fft_busy = 1;
        feed(FFT_N, 0, 1);
        chk("ready_low_after_full", o_ready, 0);
        for (int k = 0; k < 10; k++) begin
            chk("no_burst_while_busy", o_fft_valid, 0);
            cyc();
        end
        i_fft_busy = 0;
        cyc();
        for (int k = 0; k < FFT_N; k++) begin
            e = DW'(-k);
            chk("burst_valid", o_fft_valid, 1);
            chk("burst_re_ramp", o_fft_re, k);
            chk("burst_im_ramp", o_fft_im, {16'h0, e});
            cyc();
        end
        chk("burst_end_valid", o_fft_valid, 0);
        chk("burst_end_re_zero", o_fft_re, 0);
        for (int k = 0; k < FFT_N; k++) begin
            i_fft_valid = 1; i_fft_re = DW'(100 + k); i_fft_im = DW'(k);
            cyc();
        end
        i_fft_valid = 0;
        chk("last_valid", o_valid, 1);
        chk("last_bin", o_bin, 15);
        chk("last_eof", o_eof, 1);
        chk("last_re", o_re, 115);
        chk("frame_cnt_one", o_frame_cnt, 1);
        chk("ready_after_frame", o_ready, 1);
        cyc();

        // Stray FFT result while filling, then clear and set/clear collision.
        i_fft_valid = 1; cyc(); i_fft_valid = 0;
        chk("err_set", o_err, 1);
        chk("err_not_forwarded", o_valid, 0);
        i_err_clr = 1; cyc(); i_err_clr = 0;
        chk("err_cleared", o_err, 0);
        i_fft_valid = 1; i_err_clr = 1; cyc(); i_fft_valid = 0; i_err_clr = 0;
        chk("err_set_wins", o_err, 1);
        i_err_clr = 1; cyc(); i_err_clr = 0;

        // Randomized frames, then fast frames to wrap the counter.
        for (int f = 0; f < 20; f++) run_frame(1);
        run_frame(0);
        for (int f = 0; f < 234; f++) run_frame(0);
        chk("frame_cnt_wrap", o_frame_cnt, 0);

        // Reset after 7 samples discards the partial frame.
        feed(7, 0, 0);
        i_reset = 1;
        #1;
        chk("midrst_ready", o_ready, 1);
        chk("midrst_busy", o_busy, 0);
        cyc();
        i_reset = 0;
        cyc();
        run_frame(0);
        chk("fresh_frame_cnt", o_frame_cnt, 1);

        // Short result stream: FFT returns only 5 beats.
        feed(FFT_N, 0, 0);
        fft_return(3, 5, 0);
`ifdef FFT_CTRL_TIMEOUT_EN
        wait_idle();
        chk("timeout_err", o_err, 1);
        chk("timeout_busy", o_busy, 0);
        chk("timeout_frame_cnt", o_frame_cnt, 1);
        i_err_clr = 1; cyc(); i_err_clr = 0;
`else
        repeat (300) cyc();
        chk("drain_waits_busy", o_busy, 1);
        chk("drain_waits_err", o_err, 0);
        chk("drain_waits_frame_cnt", o_frame_cnt, 1);
        i_reset = 1; cyc(); cyc(); i_reset = 0;
`endif
        cyc();
        run_frame(1);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter DATA_W, 16, width of each real/imaginary sample.
REQ-002 Parameter TIMEOUT_CYC, 256, maximum DRAIN cycles before abort.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  upstream sample valid.
REQ-006 i_re, i_im  input  DATA_W each  upstream sample.
REQ-007 o_ready  output  1  upstream ready; a sample is accepted when i_valid && o_ready.
REQ-008 o_fft_valid  output  1  drives fft_16point i_valid.
REQ-009 o_fft_re, o_fft_im  output  DATA_W each  drive fft_16point i_re/i_im.
REQ-010 i_fft_valid, i_fft_busy  input  1 each  from fft_16point o_valid/o_busy.
REQ-011 i_fft_re, i_fft_im  input  DATA_W each  from fft_16point o_re/o_im.
REQ-012 i_err_clr  input  1  synchronous clear of o_err.
REQ-013 o_valid, o_re, o_im  output  1/DATA_W/DATA_W  tagged FFT result stream.
REQ-014 o_bin  output  4  bin index of current o_valid beat.
REQ-015 o_sof, o_eof  output  1 each  high with bin 0 / bin 15.
REQ-016 o_frame_cnt  output  8  completed frames, wraps 255->0.
REQ-017 o_busy, o_err  output  1 each  controller not in FILL; sticky error.

Function
REQ-018 Block SHALL implement states FILL, ARM, BURST, DRAIN with 16-entry x 2*DATA_W sample buffer.
REQ-019 FILL: o_ready=1; each accept writes buffer[wr_ptr], wr_ptr++; the 16th accept SHALL move to ARM, so o_ready is low the following cycle.
REQ-020 ARM: o_ready=0; SHALL move to BURST on first cycle with i_fft_busy=0.
REQ-021 BURST: SHALL assert o_fft_valid for exactly 16 consecutive cycles presenting buffer[0..15] in order, registered outputs; after the 16th beat SHALL move to DRAIN.
REQ-022 o_fft_re/o_fft_im SHALL be 0 whenever o_fft_valid=0.
REQ-023 Result beats (i_fft_valid=1) SHALL be counted in BURST and DRAIN; out_cnt 0..15 gives o_bin.
REQ-024 Each counted beat SHALL appear on o_valid/o_re/o_im/o_bin/o_sof/o_eof exactly 1 cycle later.
REQ-025 16th counted beat SHALL increment o_frame_cnt, clear out_cnt and, if in DRAIN, move to FILL same edge.
REQ-026 16th result beat arriving while still in BURST SHALL be counted; transition BURST->DRAIN->FILL then occurs with DRAIN lasting one cycle.
REQ-027 i_fft_valid in FILL or ARM SHALL set o_err and SHALL NOT be forwarded.
REQ-028 o_err SHALL be cleared by i_err_clr; simultaneous set and clear SHALL leave o_err=1.
REQ-029 o_busy SHALL equal (state != FILL).

Reset
REQ-030 While i_reset=1: state=FILL, wr_ptr, rd_ptr, out_cnt, timer, o_frame_cnt=0; all outputs 0 except o_ready=1.
REQ-031 Reset asserted mid-frame SHALL discard partial input and pending results; buffer contents are not reset.

Configuration
REQ-032 With FFT_CTRL_TIMEOUT_EN defined: DRAIN timer counts cycles; reaching TIMEOUT_CYC without 16th beat SHALL set o_err, clear out_cnt, leave o_frame_cnt unchanged, move to FILL.
REQ-033 Without FFT_CTRL_TIMEOUT_EN: no timer logic, DRAIN waits indefinitely; TIMEOUT_CYC unused.

Structure
REQ-034 Shared package fft_pkg SHALL hold state enum, FFT_N=16, bin-index width, default DATA_W.
REQ-035 Buffer SHALL be one sub-module fft_frame_buf (16-deep, 1 write and 1 read port, registered read).

Verification
REQ-036 Reset, feed 16 samples re=n, im=-n (n=0..15) back-to-back -> o_ready low after 16th, o_fft_valid 16 cycles with re 0..15 in order.
REQ-037 Hold i_fft_busy=1 for 10 cycles after buffer full -> BURST starts first cycle busy=0; o_fft_valid stays 0 meanwhile.
REQ-038 Model returns 16 beats -> o_bin 0..15, o_sof at bin 0, o_eof at bin 15, o_frame_cnt 0->1; 256 frames -> o_frame_cnt wraps to 0.
REQ-039 Inject i_fft_valid during FILL -> o_err=1, no o_valid; pulse i_err_clr -> o_err=0.
REQ-040 TIMEOUT_EN, TIMEOUT_CYC=256, model returns 5 beats only -> o_err=1 after 256 DRAIN cycles, state FILL, o_frame_cnt unchanged.
REQ-041 Assert i_reset after 7 accepted samples -> o_ready=1, o_busy=0; next 16 samples form a complete fresh frame.
